// File: rtl/matvec_engine.sv
// matvec_engine: matrix-vector multiply engine computing C[r] = sum_k A[r][k] * B[k].
//
// A job fetches ROWS+1 words over an Avalon-MM read master, one read outstanding at a
// time. Word 0 at base_addr is the vector B. Word 1+r is row r of A. The engine then runs
// ROWS parallel MACs over COLS cycles, one column per cycle, and holds all results in DONE.
//
// Optional feature macro: MATVEC_SIGNED_EN
//   defined   : operands are two's-complement and products are sign-extended.
//   undefined : operands are unsigned and products are zero-extended.
//
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          one-cycle job request; accepted only in IDLE or DONE
//   base_addr      word address of B; A row r is at base_addr+1+r (wraps)
//   address, read  Avalon read address and strobe
//   readdata       element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   readdatavalid  read data valid
//   waitrequest    slave stall
//   busy           job in progress (FETCH or CALC)
//   done           results valid; high until the next accepted start
//   result         C[r] at bits [r*ACC_WIDTH +: ACC_WIDTH]; wraps modulo 2^ACC_WIDTH
module matvec_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic [ADDR_WIDTH-1:0]      address,
  output logic                       read,
  input  logic [COLS*DATA_WIDTH-1:0] readdata,
  input  logic                       readdatavalid,
  input  logic                       waitrequest,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS*ACC_WIDTH-1:0]  result
);

  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WW = $clog2(ROWS + 1);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int EW = ACC_WIDTH + PW;

  typedef enum logic [1:0] {StIdle, StFetch, StCalc, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WW-1:0]         w_q;        // index of the word currently being fetched
  logic [KW-1:0]         k_q;        // column being accumulated
  logic                  pending_q;  // a read was accepted and its data has not arrived

  logic [DATA_WIDTH-1:0] b_q   [COLS];
  logic [DATA_WIDTH-1:0] a_q   [ROWS][COLS];
  logic [ACC_WIDTH-1:0]  acc_q [ROWS];
  logic [ACC_WIDTH-1:0]  acc_nxt [ROWS];
  logic [RW-1:0]         row_idx;

  // Product of one A element and one B element, extended to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [EW-1:0] ext;
`ifdef MATVEC_SIGNED_EN
    logic signed [PW-1:0] p;
    p   = $signed(a) * $signed(b);
    ext = EW'(p);
`else
    logic [PW-1:0] p;
    p   = PW'(a) * PW'(b);
    ext = EW'(p);
`endif
    return ext[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      acc_nxt[r] = acc_q[r] + mac_term(a_q[r][k_q], b_q[k_q]);
    end
  end

  // Words 1..ROWS land in A rows 0..ROWS-1.
  assign row_idx = RW'(w_q - WW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      w_q       <= '0;
      k_q       <= '0;
      pending_q <= 1'b0;
      address   <= '0;
      read      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      for (int c = 0; c < COLS; c++) begin
        b_q[c] <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        acc_q[r] <= '0;
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            base_q    <= base_addr;
            address   <= base_addr;
            read      <= 1'b1;
            w_q       <= '0;
            k_q       <= '0;
            pending_q <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            for (int r = 0; r < ROWS; r++) begin
              acc_q[r] <= '0;
            end
            state_q   <= StFetch;
          end
        end

        StFetch: begin
          if (read && !waitrequest) begin
            read      <= 1'b0;
            pending_q <= 1'b1;
          end else if (pending_q && readdatavalid) begin
            pending_q <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
              if (w_q == '0) begin
                b_q[c] <= readdata[c*DATA_WIDTH +: DATA_WIDTH];
              end else begin
                a_q[row_idx][c] <= readdata[c*DATA_WIDTH +: DATA_WIDTH];
              end
            end
            if (w_q == WW'(ROWS)) begin
              state_q <= StCalc;
            end else begin
              w_q     <= w_q + WW'(1);
              address <= base_q + ADDR_WIDTH'(w_q) + ADDR_WIDTH'(1);
              read    <= 1'b1;
            end
          end
        end

        StCalc: begin
          for (int r = 0; r < ROWS; r++) begin
            acc_q[r] <= acc_nxt[r];
          end
          if (k_q == KW'(COLS - 1)) begin
            for (int r = 0; r < ROWS; r++) begin
              result[r*ACC_WIDTH +: ACC_WIDTH] <= acc_nxt[r];
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
